fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, 32, instruction and address width.
REQ-002 Parameter DEPTH, 4, prefetch queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-004 Port clk  input  1  single clock; every register updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port fetch_en  input  1  permits a fetch this cycle.
REQ-007 Port imem_addr  output  XLEN  instruction memory address (current PCF).
REQ-008 Port imem_rdata  input  XLEN  instruction word; combinational from imem_addr, same cycle.
REQ-009 Port redirect  input  1  taken branch or jump from Execute (PCSrcE).
REQ-010 Port redirect_pc  input  XLEN  redirect target (PCTargetE).
REQ-011 Port out_valid  output  1  head entry is valid.
REQ-012 Port out_ready  input  1  Decode accepts the head entry (driven as not StallD).
REQ-013 Port out_instr  output  XLEN  head instruction; 32'h0000_0013 (NOP) when out_valid is 0.
REQ-014 Port out_pc  output  XLEN  PC of the head instruction.
REQ-015 Port out_pcplus4  output  XLEN  out_pc+4.
REQ-016 Port count  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH.

Function
REQ-017 imem_addr SHALL equal the PC register.
REQ-018 push = fetch_en & !redirect & (count<DEPTH | pop).
REQ-019 pop = out_valid & out_ready & !redirect.
REQ-020 On push, the queue SHALL write {imem_rdata, PC} at the tail, and PC SHALL become PC+4 (mod 2^XLEN).
REQ-021 Without push or redirect, PC SHALL hold.
REQ-022 On pop, the head SHALL advance; push and pop in the same cycle SHALL leave count unchanged, including when count=DEPTH.
REQ-023 Latency: an instruction pushed in cycle N SHALL appear at the head no earlier than cycle N+1; there is no combinational bypass.
REQ-024 out_valid SHALL equal (count!=0); out_* SHALL be driven from the head entry.
REQ-025 On redirect, the next edge SHALL load PC with redirect_pc, clear every entry, and set count=0; redirect overrides push and pop that cycle.
REQ-026 After a redirect, the first fetch SHALL take place at redirect_pc in the following cycle if fetch_en is 1.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or fall below 0.
REQ-028 out_valid, out_instr, out_pc and out_pcplus4 SHALL stay stable while out_valid & !out_ready & !redirect.
REQ-029 redirect_pc SHALL be taken as given, with no alignment check.

Reset
REQ-030 On reset: PC=RESET_PC, head=tail=0, count=0, out_valid=0, out_instr=NOP, out_pc=0, out_pcplus4=4.
REQ-031 Reset SHALL override redirect, push and pop.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries in one cycle.

Structure
REQ-033 A shared package SHALL hold the NOP encoding 32'h0000_0013 and the default RESET_PC.
REQ-034 The PC+4 increment SHALL reuse the existing adder module; a single sub-module, fetch_fifo (storage, pointers, count), is natural.
REQ-035 Storage SHALL be a register array, not inferred RAM, so that a single-cycle flush is possible.

Verification
REQ-036 Reset, then fetch_en=1 and out_ready=0 for 6 cycles -> count=4, out_pc=0x0, PC=0x10, no pushes after the queue is full.
REQ-037 Queue full, out_ready=1 and fetch_en=1 -> count stays 4, out_pc steps 0x0, 0x4, 0x8, and PC advances by 4 each cycle.
REQ-038 count=3 and redirect=1 with redirect_pc=0x100 -> next cycle count=0, out_valid=0, out_instr=NOP; the following cycle out_pc=0x100.
REQ-039 Redirect, push and pop in the same cycle -> no entry is popped or written, and PC=redirect_pc.
REQ-040 Queue full at tail=2 with 10 alternating push/pop cycles -> pointers wrap and every instruction is delivered once, in order.
REQ-041 reset asserted with count=2 and redirect=1 -> PC=RESET_PC and count=0, regardless of redirect.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue slice: NOP encoding and default reset PC.
package fetch_queue_pkg;

   localparam int unsigned INSTR_W          = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_queue_pkg

// File: rtl/adder.sv
// Plain WIDTH-bit adder, wraps modulo 2^WIDTH.
// Ports: a, b (operands), y (sum).
module adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = a + b;

endmodule : adder

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: register-array prefetch queue holding {instr, pc} pairs.
// Ports: clk, reset (sync, active-high), flush (clears all entries in one cycle),
//        push/wrInstr/wrPc (tail write), pop (head advance),
//        headInstr/headPc (head entry), count (occupancy 0..DEPTH).
module fetch_fifo #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [XLEN-1:0]  wrInstr,
   input  logic [XLEN-1:0]  wrPc,
   input  logic             pop,
   output logic [XLEN-1:0]  headInstr,
   output logic [XLEN-1:0]  headPc,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [XLEN-1:0]  instrMem [DEPTH];
   logic [XLEN-1:0]  pcMem    [DEPTH];
   logic [PTR_W-1:0] headPtr;
   logic [PTR_W-1:0] tailPtr;

   // Storage, pointers and occupancy; reset and flush both empty the queue.
   // DEPTH is a power of two, so pointer increments wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            instrMem[i] <= '0;
            pcMem[i]    <= '0;
         end
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            instrMem[tailPtr] <= wrInstr;
            pcMem[tailPtr]    <= wrPc;
            tailPtr           <= tailPtr + PTR_W'(1);
         end
         if (pop) begin
            headPtr <= headPtr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign headInstr = instrMem[headPtr];
   assign headPc    = pcMem[headPtr];

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// fetch_queue: PC register plus prefetch queue between Fetch and Decode.
// Ports: clk, reset (sync, active-high), fetch_en, imem_addr/imem_rdata
//        (combinational instruction memory), redirect/redirect_pc (from Execute),
//        out_valid/out_ready/out_instr/out_pc/out_pcplus4 (head to Decode), count.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_en,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [XLEN-1:0]            imem_rdata,
   input  logic                       redirect,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_instr,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_pcplus4,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0] pcF;
   logic [XLEN-1:0] pcPlus4F;
   logic [XLEN-1:0] headInstr;
   logic [XLEN-1:0] headPc;
   logic            pushEn;
   logic            popEn;

   // A full queue may still accept a push when the head leaves in the same cycle.
   assign popEn  = out_valid & out_ready & ~redirect;
   assign pushEn = fetch_en & ~redirect & ((count < CNT_W'(DEPTH)) | popEn);

   adder #(.WIDTH(XLEN)) pcIncr (
      .a (pcF),
      .b (XLEN'(4)),
      .y (pcPlus4F)
   );

   // PC register: reset beats redirect, redirect beats sequential fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcF <= RESET_PC;
      end else if (redirect) begin
         pcF <= redirect_pc;
      end else if (pushEn) begin
         pcF <= pcPlus4F;
      end
   end

   fetch_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (pushEn),
      .wrInstr   (imem_rdata),
      .wrPc      (pcF),
      .pop       (popEn),
      .headInstr (headInstr),
      .headPc    (headPc),
      .count     (count)
   );

   // Cleared entries hold pc 0, so out_pc/out_pcplus4 read 0/4 when empty after reset.
   adder #(.WIDTH(XLEN)) headIncr (
      .a (headPc),
      .b (XLEN'(4)),
      .y (out_pcplus4)
   );

   assign imem_addr = pcF;
   assign out_valid = (count != '0);
   assign out_instr = out_valid ? headInstr : XLEN'(NOP_INSTR);
   assign out_pc    = headPc;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus process queues each expected
// push; a negedge monitor pops and compares whenever Decode accepts the head.
module tb_fetch_queue;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus4;
   logic [2:0]  count;

   int     nTests = 0;
   int     nFail  = 0;
   bit     known  = 1'b0;
   entry_t sb[$];
   logic [31:0] mPc;
   int     mCnt;

   always #5 clk = ~clk;

   function automatic logic [31:0] instrOf(logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign imem_rdata = instrOf(imem_addr);

   fetch_queue dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_en    (fetch_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pcplus4 (out_pcplus4),
      .count       (count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset === 1'b0 && redirect === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_pop", out_pc, 32'hFFFF_FFFF);
         end else begin
            entry_t e;
            e = sb.pop_front();
            check("sb_instr", out_instr, e.instr);
            check("sb_pc", out_pc, e.pc);
            check("sb_pcplus4", out_pcplus4, e.pc + 32'd4);
         end
      end
   end

   // One clock: apply inputs, check PC/count against the model before the edge, advance model.
   task automatic step(input bit rst, input bit fe, input bit rdy, input bit rd, input logic [31:0] rdPc);
      bit pushM, popM;
      reset = rst; fetch_en = fe; out_ready = rdy; redirect = rd; redirect_pc = rdPc;
      @(negedge clk);
      if (known) begin
         check("imem_addr", imem_addr, mPc);
         check("count", 32'(count), 32'(mCnt));
      end
      if (rst) begin
         sb.delete(); mPc = 32'h0; mCnt = 0;
      end else if (rd) begin
         sb.delete(); mPc = rdPc; mCnt = 0;
      end else begin
         popM  = (mCnt != 0) && rdy;
         pushM = fe && ((mCnt < 4) || popM);
         if (pushM) begin
            sb.push_back('{instr: instrOf(mPc), pc: mPc});
            mPc = mPc + 32'd4;
         end
         mCnt = mCnt + int'(pushM) - int'(popM);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      mPc = 32'h0; mCnt = 0;
      step(1, 0, 0, 0, 0);
      known = 1'b1;
      step(1, 0, 0, 0, 0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_instr", out_instr, 32'h0000_0013);
      check("rst_pc", out_pc, 32'h0);
      check("rst_pcplus4", out_pcplus4, 32'h4);
      check("rst_count", 32'(count), 32'h0);
      check("rst_addr", imem_addr, 32'h0);

      // Fill with Decode stalled.
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
      check("fill_count", 32'(count), 32'd4);
      check("fill_out_pc", out_pc, 32'h0);
      check("fill_out_instr", out_instr, 32'hDEAD_0000);
      check("fill_addr", imem_addr, 32'h10);

      // Full queue streaming: simultaneous push and pop.
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
      check("stream_count", 32'(count), 32'd4);
      check("stream_addr", imem_addr, 32'h1C);

      // count=3 then redirect with push and pop also requested.
      step(0, 0, 1, 0, 0);
      check("pre_redir_count", 32'(count), 32'd3);
      step(0, 1, 1, 1, 32'h100);
      check("redir_count", 32'(count), 32'd0);
      check("redir_valid", 32'(out_valid), 32'h0);
      check("redir_instr", out_instr, 32'h0000_0013);
      check("redir_addr", imem_addr, 32'h100);
      step(0, 1, 0, 0, 0);
      check("redir_out_pc", out_pc, 32'h100);
      check("redir_out_valid", 32'(out_valid), 32'h1);

      // Move to full with tail=2, then alternate pop/push to wrap pointers.
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
      check("tail2_count", 32'(count), 32'd4);
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) step(0, 0, 1, 0, 0);
         else            step(0, 1, 0, 0, 0);
      end
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
      check("drain_count", 32'(count), 32'd0);
      check("drain_sb_left", 32'(sb.size()), 32'd0);

      // Reset overrides a simultaneous redirect.
      for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
      check("pre_rst_count", 32'(count), 32'd2);
      step(1, 1, 1, 1, 32'h200);
      check("rst_redir_addr", imem_addr, 32'h0);
      check("rst_redir_count", 32'(count), 32'd0);
      check("rst_redir_valid", 32'(out_valid), 32'h0);

      // PC wraps modulo 2^32.
      step(0, 1, 1, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0);
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
      check("wrap_pcplus4", out_pcplus4, 32'h0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      check("final_sb_left", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule : tb_fetch_queue
